// File: rtl/nonce_pkg.sv
// Shared helpers for the nonce result collector: search-range math, core
// index width and the FSM state encoding.
package nonce_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  // Width of each core's search range; core i starts at i*ROLL.
  function automatic logic [31:0] roll_f(input int ncore);
    return 32'hFFFF_FFFF / 32'(ncore);
  endfunction

  function automatic int core_w_f(input int ncore);
    return (ncore <= 1) ? 1 : $clog2(ncore);
  endfunction

endpackage

// File: rtl/nonce_result_collector_result_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; push is ignored when full
// and pop is ignored when empty.
module result_fifo #(
  parameter type T     = logic [31:0],
  parameter int  DEPTH = 4
) (
  input  logic clk,
  input  logic clear,
  input  logic push,
  input  T     din,
  output logic full,
  input  logic pop,
  output logic empty,
  output T     head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/nonce_result_collector.sv
// Maps per-core golden-hash hits back to absolute nonces and queues them,
// lowest core first, toward the host link.
module nonce_result_collector
  import nonce_pkg::*;
#(
  parameter int NCORE      = 1,
  parameter int FIFO_DEPTH = 4,
  localparam int CORE_W    = core_w_f(NCORE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_clear,
  input  logic              hit_valid,
  input  logic [NCORE-1:0]  hit_vec,
  input  logic [31:0]       nonce_base,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_nonce,
  output logic [CORE_W-1:0] out_core,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  localparam logic [31:0] ROLL = roll_f(NCORE);

  typedef struct packed {
    logic [31:0]       nonce;
    logic [CORE_W-1:0] core;
  } result_t;

  state_t             state, state_n;
  logic [NCORE-1:0]   pending, pending_n;
  logic [31:0]        base, base_n;
  logic [CORE_W-1:0]  idx;
  logic [NCORE-1:0]   low_bit;
  logic               push;
  logic               full;
  logic               empty;
  logic               flush;
  result_t            din;
  result_t            head;

  assign flush = rst || job_clear;

  always_comb begin
    idx = '0;
    for (int i = NCORE - 1; i >= 0; i--) begin
      if (pending[i]) idx = CORE_W'(i);
    end
  end

  // Isolates the lowest set bit so it can be cleared once pushed.
  assign low_bit   = pending & (~pending + NCORE'(1));
  assign din.core  = idx;
  assign din.nonce = base + (32'(idx) * ROLL);

  always_ff @(posedge clk) begin
    if (flush) begin
      state      <= IDLE;
      pending    <= '0;
      base       <= '0;
      overflow   <= 1'b0;
      drop_count <= '0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      base    <= base_n;
      if (hit_valid && state == SCAN) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    base_n    = base;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (hit_valid && (hit_vec != '0)) begin
          pending_n = hit_vec;
          base_n    = nonce_base;
          state_n   = SCAN;
        end
      end
      SCAN: begin
        if (!full) begin
          push      = 1'b1;
          pending_n = pending & ~low_bit;
          if (pending_n == '0) state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  result_fifo #(
    .T     (result_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .clear (flush),
    .push  (push),
    .din   (din),
    .full  (full),
    .pop   (out_valid && out_ready),
    .empty (empty),
    .head  (head)
  );

  assign out_valid = !empty;
  assign out_nonce = out_valid ? head.nonce : '0;
  assign out_core  = out_valid ? head.core : '0;
  assign busy      = (state == SCAN);

endmodule

// File: tb/tb_nonce_result_collector.sv
// Directed bench for nonce_result_collector with NCORE=4, FIFO_DEPTH=4.
module tb_nonce_result_collector;

  localparam int NCORE = 4;
  localparam int CW    = 2;
  localparam int RW    = 32 + CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          job_clear = 1'b0;
  logic          hit_valid = 1'b0;
  logic [3:0]    hit_vec = '0;
  logic [31:0]   nonce_base = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_nonce;
  logic [CW-1:0] out_core;
  logic          busy;
  logic          overflow;
  logic [7:0]    drop_count;

  logic [RW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int vld_cnt = 0;
  int busy_cnt = 0;

  nonce_result_collector #(.NCORE(NCORE), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .job_clear  (job_clear),
    .hit_valid  (hit_valid),
    .hit_vec    (hit_vec),
    .nonce_base (nonce_base),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_nonce  (out_nonce),
    .out_core   (out_core),
    .busy       (busy),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hit(input logic [3:0] v, input logic [31:0] b);
    hit_valid  = 1'b1;
    hit_vec    = v;
    nonce_base = b;
    step(1);
    hit_valid  = 1'b0;
  endtask

  task automatic expect_res(input logic [31:0] n, input logic [CW-1:0] c);
    exp_q.push_back({n, c});
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ovf"}, 64'(overflow), 64'd0);
    chk({tag, "_drops"}, 64'(drop_count), 64'd0);
    chk({tag, "_nonce"}, 64'(out_nonce), 64'd0);
    chk({tag, "_core"}, 64'(out_core), 64'd0);
  endtask

  // Monitor: every accepted output beat is matched against the expected queue.
  always @(negedge clk) begin
    if (out_valid) vld_cnt++;
    if (busy) busy_cnt++;
    if (!rst && !job_clear && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got nonce 0x%0h core %0d, expected none", out_nonce, out_core);
      end else begin
        chk("result", 64'({out_nonce, out_core}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    step(3);
    rst = 1'b0;
    @(negedge clk);
    chk_idle("reset");

    // Single hit, core 2: 0x10 + 2*0x3FFFFFFF
    out_ready = 1'b1;
    vld_cnt = 0;
    expect_res(32'h8000_000E, 2'd2);
    hit(4'b0100, 32'h10);
    @(negedge clk);
    chk("t1_lat_valid", 64'(out_valid), 64'd0);
    chk("t1_lat_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("t1_valid", 64'(out_valid), 64'd1);
    step(4);
    chk("t1_valid_cycles", 64'(vld_cnt), 64'd1);

    // Three hits in ascending core order
    busy_cnt = 0;
    expect_res(32'h0000_0005, 2'd0);
    expect_res(32'h4000_0004, 2'd1);
    expect_res(32'hC000_0002, 2'd3);
    hit(4'b1011, 32'h5);
    step(6);
    chk("t2_busy_cycles", 64'(busy_cnt), 64'd3);
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // Wrap-around of the 32-bit add
    expect_res(32'h0000_000D, 2'd3);
    hit(4'b1000, 32'h4000_0010);
    step(4);
    chk("t3_drained", 64'(exp_q.size()), 64'd0);

    // Backpressure: fill FIFO, stall a scan, drop a round, then drain
    out_ready = 1'b0;
    expect_res(32'h0000_0100, 2'd0);
    expect_res(32'h4000_00FF, 2'd1);
    expect_res(32'h8000_00FE, 2'd2);
    expect_res(32'hC000_00FD, 2'd3);
    hit(4'b1111, 32'h100);
    step(5);
    @(negedge clk);
    chk("t4_full_busy", 64'(busy), 64'd0);
    chk("t4_full_valid", 64'(out_valid), 64'd1);
    expect_res(32'h0000_0200, 2'd0);
    hit(4'b0001, 32'h200);
    step(2);
    @(negedge clk);
    chk("t4_stall_busy", 64'(busy), 64'd1);
    hit(4'b0010, 32'h300);
    @(negedge clk);
    chk("t4_ovf", 64'(overflow), 64'd1);
    chk("t4_drops", 64'(drop_count), 64'd1);
    out_ready = 1'b1;
    step(10);
    @(negedge clk);
    chk("t4_end_busy", 64'(busy), 64'd0);
    chk("t4_end_valid", 64'(out_valid), 64'd0);
    chk("t4_drained", 64'(exp_q.size()), 64'd0);

    // job_clear mid-scan with results queued and a sticky overflow
    out_ready = 1'b0;
    hit(4'b1111, 32'h0);
    step(2);
    hit(4'b0001, 32'h0);
    job_clear = 1'b1;
    step(1);
    job_clear = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_idle("t5_clear");
    out_ready = 1'b1;
    expect_res(32'h0000_1234, 2'd0);
    hit(4'b0001, 32'h1234);
    step(4);
    chk("t5_drained", 64'(exp_q.size()), 64'd0);

    // Drop counter saturation, then reset
    out_ready = 1'b0;
    hit(4'b1111, 32'h0);
    step(5);
    hit(4'b0001, 32'h0);
    hit_valid = 1'b1;
    hit_vec = 4'b0001;
    step(300);
    hit_valid = 1'b0;
    @(negedge clk);
    chk("t6_busy", 64'(busy), 64'd1);
    chk("t6_ovf", 64'(overflow), 64'd1);
    chk("t6_drops_sat", 64'(drop_count), 64'd255);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_idle("t6_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
